// File: rtl/seg_pkg.sv
// Shared definitions for the score display: converter state encoding,
// active-low seven-segment codes, digit-count limits and helper functions.
// No ports (package).
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } conv_state_t;

  localparam int MIN_DIGITS = 1;
  localparam int MAX_DIGITS = 8;

  // Active-low segments, bit 0 = a ... bit 6 = g, bit 7 = dp (kept dark)
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic bit digits_in_range(input int n);
    return (n >= MIN_DIGITS) && (n <= MAX_DIGITS);
  endfunction

  // Largest value representable in n decimal digits (10^n - 1)
  function automatic logic [63:0] max_bcd_value(input int n);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < n; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with saturation detect
// and a one-deep pending-load register.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   score    : unsigned binary value, captured on an accepted load
//   load     : load request level
//   busy     : converter not idle
//   bcd      : BCD result (valid while done is high)
//   done     : one-cycle strobe in LATCH
//   sat      : value of the current conversion exceeds NUM_DIGITS digits
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_W    = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SCORE_W-1:0]      score,
  input  logic                    load,
  output logic                    busy,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    done,
  output logic                    sat
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam logic [63:0] SAT_LIMIT = max_bcd_value(NUM_DIGITS);

  conv_state_t        state;
  logic [SCORE_W-1:0] bin_sr;
  logic [BCD_W-1:0]   bcd_acc;
  logic [CNT_W-1:0]   iter;
  logic               sat_r;
  logic               pend_flag;
  logic [SCORE_W-1:0] pend_val;
  logic [BCD_W-1:0]   adj;
  logic [SCORE_W-1:0] cap_val;

  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic over_limit(input logic [SCORE_W-1:0] v);
    return 64'(v) > SAT_LIMIT;
  endfunction

  assign adj = dabble_adjust(bcd_acc);
  // In LATCH a load arriving that very cycle is newer than the pending one
  assign cap_val = (state == LATCH && !load) ? pend_val : score;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bin_sr    <= '0;
      bcd_acc   <= '0;
      iter      <= '0;
      sat_r     <= 1'b0;
      pend_flag <= 1'b0;
      pend_val  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bin_sr  <= cap_val;
            sat_r   <= over_limit(cap_val);
            bcd_acc <= '0;
            iter    <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Top-nibble carries fall off; sat covers any value that needs them
          bcd_acc <= {adj[BCD_W-2:0], bin_sr[SCORE_W-1]};
          bin_sr  <= bin_sr << 1;
          if (iter == CNT_W'(SCORE_W - 1)) state <= LATCH;
          else                             iter  <= iter + 1'b1;
          if (load) begin
            pend_val  <= score;
            pend_flag <= 1'b1;
          end
        end
        LATCH: begin
          pend_flag <= 1'b0;
          if (load || pend_flag) begin
            bin_sr  <= cap_val;
            sat_r   <= over_limit(cap_val);
            bcd_acc <= '0;
            iter    <= '0;
            state   <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == LATCH);
  assign bcd  = bcd_acc;
  assign sat  = sat_r;

endmodule

// File: rtl/score_display_mux.sv
// Score display: converts a binary score to BCD (saturating at all nines),
// holds it in a display register and scans it onto a time-multiplexed,
// active-low seven-segment display with optional leading-zero blanking.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_score      : unsigned score, sampled on an accepted load
//   i_load       : conversion request level
//   o_busy       : converter busy
//   o_overflow   : last latched value was saturated
//   o_seg        : active-low segments (bit 7 = dp, always 1)
//   o_an         : active-low digit enables, bit 0 = least significant digit
module score_display_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SCORE_W       = 14,
  parameter int SCAN_DIV      = 100000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [SCORE_W-1:0]    i_score,
  input  logic                  i_load,
  output logic                  o_busy,
  output logic                  o_overflow,
  output logic [7:0]            o_seg,
  output logic [NUM_DIGITS-1:0] o_an
);

  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (!digits_in_range(NUM_DIGITS)) begin : g_bad_digits
    $error("NUM_DIGITS must be between 1 and 8");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan
    $error("SCAN_DIV must be at least 2");
  end

  logic [BCD_W-1:0]      conv_bcd;
  logic                  conv_done;
  logic                  conv_sat;
  logic [BCD_W-1:0]      disp_reg;
  logic                  ovf_r;
  logic [CNT_W-1:0]      scan_cnt;
  logic [IDX_W-1:0]      dig_idx;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic                  lead;
  logic [3:0]            cur_nib;
  logic                  cur_blank;
  logic [7:0]            seg_p1;
  logic [NUM_DIGITS-1:0] an_p1;

  bin2bcd_seq #(
    .NUM_DIGITS(NUM_DIGITS),
    .SCORE_W   (SCORE_W)
  ) u_conv (
    .clk  (i_clk),
    .rst  (i_rst),
    .score(i_score),
    .load (i_load),
    .busy (o_busy),
    .bcd  (conv_bcd),
    .done (conv_done),
    .sat  (conv_sat)
  );

  // Display register: only written on completed conversions
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      disp_reg <= '0;
      ovf_r    <= 1'b0;
    end else if (conv_done) begin
      disp_reg <= conv_sat ? {NUM_DIGITS{4'h9}} : conv_bcd;
      ovf_r    <= conv_sat;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      dig_idx  <= (dig_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : dig_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // A digit is blank while it and everything above it are zero; digit 0 never
  always_comb begin
    blank_mask = '0;
    lead       = (BLANK_LEADING != 0);
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (disp_reg[4*i +: 4] != 4'd0) lead = 1'b0;
      blank_mask[i] = lead;
    end
  end

  always_comb begin
    cur_nib   = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_idx == IDX_W'(i)) begin
        cur_nib   = disp_reg[4*i +: 4];
        cur_blank = blank_mask[i];
      end
    end
  end

  // p1: segments and anode registered together so digits never ghost
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      seg_p1 <= SEG_BLANK;
      an_p1  <= '1;
    end else begin
      seg_p1 <= cur_blank ? SEG_BLANK : seg_encode(cur_nib);
      an_p1  <= ~(NUM_DIGITS'(1) << dig_idx);
    end
  end

  assign o_seg      = seg_p1;
  assign o_an       = an_p1;
  assign o_overflow = ovf_r;

endmodule
